// File: rtl/axi_pkg.sv
// Shared definitions for the two-master AXI3 write arbiter: payload layouts,
// response codes and the transaction-phase encoding.
package axi_pkg;

    localparam int N_REQ   = 2;
    localparam int AWPAY_W = 45;
    localparam int WPAY_W  = 37;
    localparam int BPAY_W  = 6;

    // AW payload: {AWID[3:0], AWADDR[31:0], AWLEN[3:0], AWSIZE[2:0], AWBURST[1:0]}
    localparam int AWBURST_LSB = 0;
    localparam int AWSIZE_LSB  = 2;
    localparam int AWLEN_LSB   = 5;
    localparam int AWADDR_LSB  = 9;
    localparam int AWID_LSB    = 41;

    // W payload: {WDATA[31:0], WSTRB[3:0], WLAST}
    localparam int WLAST_BIT = 0;
    localparam int WSTRB_LSB = 1;
    localparam int WDATA_LSB = 5;

    // B payload: {BID[3:0], BRESP[1:0]}
    localparam int BRESP_LSB = 0;
    localparam int BID_LSB   = 2;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AW   = 2'd1,
        ST_W    = 2'd2,
        ST_B    = 2'd3
    } state_t;

endpackage

// File: rtl/axi_wr_arb_rr_arb2.sv
// Two-way round-robin picker: the requester after the last winner is preferred.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (last) begin
            if (req[0])      gnt = 2'b01;
            else if (req[1]) gnt = 2'b10;
        end else begin
            if (req[1])      gnt = 2'b10;
            else if (req[0]) gnt = 2'b01;
        end
    end

endmodule

// File: rtl/axi_wr_arb.sv
// Shares one AXI3 write port between two masters, one whole transaction
// (address, data beats, response) at a time, in round-robin order.
module axi_wr_arb
    import axi_pkg::*;
(
    input  logic                      ACLK,
    input  logic                      ARESET,
    input  logic [N_REQ-1:0]          S_AWVALID,
    output logic [N_REQ-1:0]          S_AWREADY,
    input  logic [N_REQ*AWPAY_W-1:0]  S_AWPAY,
    input  logic [N_REQ-1:0]          S_WVALID,
    output logic [N_REQ-1:0]          S_WREADY,
    input  logic [N_REQ*WPAY_W-1:0]   S_WPAY,
    output logic [N_REQ-1:0]          S_BVALID,
    input  logic [N_REQ-1:0]          S_BREADY,
    output logic [BPAY_W-1:0]         S_BPAY,
    output logic                      M_AWVALID,
    input  logic                      M_AWREADY,
    output logic [AWPAY_W-1:0]        M_AWPAY,
    output logic                      M_WVALID,
    input  logic                      M_WREADY,
    output logic [WPAY_W-1:0]         M_WPAY,
    input  logic                      M_BVALID,
    output logic                      M_BREADY,
    input  logic [BPAY_W-1:0]         M_BPAY,
    output logic [N_REQ-1:0]          GRANT,
    output logic                      ERR
);

    state_t               state_reg;
    logic                 last_grant_reg;
    logic [N_REQ-1:0]     grant_reg;
    logic                 m_awvalid_reg;
    logic [AWPAY_W-1:0]   m_awpay_reg;
    logic [3:0]           beat_cnt_reg;
    logic [3:0]           awid_reg;
    logic [3:0]           awlen_reg;
    logic                 err_reg;

    logic [N_REQ-1:0]     pick;
    logic                 pick_idx;
    logic                 g_idx;
    logic                 aw_open;
    logic                 aw_take;
    logic                 w_beat;
    logic                 b_take;
    logic                 wlast_gen;
    logic [AWPAY_W-1:0]   s_awpay_arr [N_REQ];
    logic [WPAY_W-1:0]    s_wpay_arr  [N_REQ];
    logic [AWPAY_W-1:0]   win_awpay_tagged;
    logic [WPAY_W-1:0]    g_wpay;

    rr_arb2 u_rr (
        .req  (S_AWVALID),
        .last (last_grant_reg),
        .gnt  (pick)
    );

    assign pick_idx = pick[1];
    assign g_idx    = grant_reg[1];
    // S_AWREADY is held low while reset is applied, independent of the request inputs
    assign aw_open  = (state_reg == ST_IDLE) && !ARESET;
    assign aw_take  = aw_open && (pick != '0);

    genvar gi;
    for (gi = 0; gi < N_REQ; gi++) begin : g_req
        assign s_awpay_arr[gi] = S_AWPAY[gi*AWPAY_W +: AWPAY_W];
        assign s_wpay_arr[gi]  = S_WPAY[gi*WPAY_W +: WPAY_W];
        assign S_AWREADY[gi]   = aw_open && pick[gi];
        assign S_WREADY[gi]    = (state_reg == ST_W) && grant_reg[gi] && M_WREADY;
        assign S_BVALID[gi]    = (state_reg == ST_B) && grant_reg[gi] && M_BVALID;
    end

    // Top ID bit carries the requester index so responses can be traced downstream
    always_comb begin
        win_awpay_tagged               = s_awpay_arr[pick_idx];
        win_awpay_tagged[AWID_LSB + 3] = pick_idx;
    end

    assign g_wpay    = s_wpay_arr[g_idx];
    assign wlast_gen = (beat_cnt_reg == awlen_reg);
    assign M_WVALID  = (state_reg == ST_W) && S_WVALID[g_idx];
    assign w_beat    = M_WVALID && M_WREADY;
    assign M_WPAY    = {g_wpay[WPAY_W-1:WLAST_BIT+1], wlast_gen};
    assign M_BREADY  = (state_reg == ST_B) && S_BREADY[g_idx];
    assign b_take    = M_BREADY && M_BVALID;
    assign S_BPAY    = {awid_reg, M_BPAY[BRESP_LSB +: 2]};

    assign M_AWVALID = m_awvalid_reg;
    assign M_AWPAY   = m_awpay_reg;
    assign GRANT     = grant_reg;
    assign ERR       = err_reg;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_reg      <= ST_IDLE;
            last_grant_reg <= 1'b1;
            grant_reg      <= '0;
            m_awvalid_reg  <= 1'b0;
            m_awpay_reg    <= '0;
            beat_cnt_reg   <= '0;
            awid_reg       <= '0;
            awlen_reg      <= '0;
            err_reg        <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (aw_take) begin
                        m_awpay_reg   <= win_awpay_tagged;
                        awid_reg      <= s_awpay_arr[pick_idx][AWID_LSB +: 4];
                        awlen_reg     <= s_awpay_arr[pick_idx][AWLEN_LSB +: 4];
                        grant_reg     <= pick;
                        m_awvalid_reg <= 1'b1;
                        state_reg     <= ST_AW;
                    end
                end
                ST_AW: begin
                    if (M_AWREADY) begin
                        m_awvalid_reg <= 1'b0;
                        beat_cnt_reg  <= '0;
                        state_reg     <= ST_W;
                    end
                end
                ST_W: begin
                    // Length comes from AWLEN; a disagreeing master WLAST only flags ERR
                    if (w_beat) begin
                        beat_cnt_reg <= beat_cnt_reg + 4'd1;
                        if (g_wpay[WLAST_BIT] != wlast_gen) err_reg <= 1'b1;
                        if (wlast_gen) state_reg <= ST_B;
                    end
                end
                ST_B: begin
                    if (b_take) begin
                        if (M_BPAY[BID_LSB +: 4] != m_awpay_reg[AWID_LSB +: 4]) err_reg <= 1'b1;
                        last_grant_reg <= g_idx;
                        grant_reg      <= '0;
                        state_reg      <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_wr_arb.sv
// Randomised and directed bench for axi_wr_arb with a transaction-level model
// checked on every cycle.
module tb_axi_wr_arb;
    import axi_pkg::*;

    logic ACLK = 1'b0;
    logic ARESET;
    logic [1:0] S_AWVALID, S_AWREADY, S_WVALID, S_WREADY, S_BVALID, S_BREADY;
    logic [2*AWPAY_W-1:0] S_AWPAY;
    logic [2*WPAY_W-1:0]  S_WPAY;
    logic [BPAY_W-1:0]    S_BPAY;
    logic M_AWVALID, M_AWREADY, M_WVALID, M_WREADY, M_BVALID, M_BREADY;
    logic [AWPAY_W-1:0] M_AWPAY;
    logic [WPAY_W-1:0]  M_WPAY;
    logic [BPAY_W-1:0]  M_BPAY;
    logic [1:0] GRANT;
    logic ERR;

    int tests = 0;
    int fails = 0;
    bit chk_en = 0;

    always #5 ACLK = ~ACLK;

    axi_wr_arb dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY), .S_AWPAY(S_AWPAY),
        .S_WVALID(S_WVALID), .S_WREADY(S_WREADY), .S_WPAY(S_WPAY),
        .S_BVALID(S_BVALID), .S_BREADY(S_BREADY), .S_BPAY(S_BPAY),
        .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY), .M_AWPAY(M_AWPAY),
        .M_WVALID(M_WVALID), .M_WREADY(M_WREADY), .M_WPAY(M_WPAY),
        .M_BVALID(M_BVALID), .M_BREADY(M_BREADY), .M_BPAY(M_BPAY),
        .GRANT(GRANT), .ERR(ERR)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- stimulus knobs and per-requester driver state ----------------
    typedef struct { int id; int len; int bad; } txn_t;
    txn_t rq_q [2][$];
    txn_t t;
    int   rq_active [2];
    int   rq_awdone [2];
    int   rq_beat   [2];
    int   rq_len    [2];
    int   rq_bad    [2];
    logic [3:0]  rq_id   [2];
    logic [31:0] rq_addr [2];
    int   rand_mode = 0;
    int   wr_mode = 0;
    int   bid_force = -1;
    int   bid_bad_pct = 0;
    logic wl;
    logic wr_tog;
    logic dn_pend;
    logic [3:0] dn_id, dn_bid;
    logic [1:0] dn_resp;

    // handshake flags seen at the falling edge, consumed by the driver
    logic [1:0] f_aw, f_w, f_b;
    logic f_maw, f_mw_last, f_mb;
    logic [3:0] f_dnid;

    // ---------------- observation logs ----------------
    logic [1:0] lg_grant [$];
    logic [3:0] lg_dnid  [$];
    int         lg_beats [$];
    int         lg_lastidx [$];
    int         lg_lastcnt [$];
    logic [3:0] lg_bid   [$];
    int mon_beats, mon_lastidx, mon_lastcnt;

    // ---------------- behavioural model ----------------
    int   m_owner;      // -1 when no transaction is open
    int   m_last;       // index of the most recent completed winner
    bit   m_aw_out;     // address not yet taken downstream
    int   m_left;       // data beats still owed
    int   m_beat;
    int   m_len;
    logic [3:0]  m_id;
    logic [44:0] m_awpay;
    logic m_err;
    logic [44:0] mp;
    int   win;
    logic [1:0] e_awr, e_wr, e_bv, e_gr;
    logic e_awv, e_wv, e_br;

    always @(posedge ACLK) begin
        #1;
        if (ARESET) begin
            for (int i = 0; i < 2; i++) begin
                rq_active[i] = 0; rq_awdone[i] = 0; rq_beat[i] = 0;
                rq_q[i].delete();
            end
            S_AWVALID = '0; S_WVALID = '0; S_BREADY = '0;
            M_AWREADY = 1'b0; M_WREADY = 1'b0; M_BVALID = 1'b0;
            dn_pend = 1'b0; wr_tog = 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (f_aw[i]) rq_awdone[i] = 1;
                if (f_w[i])  rq_beat[i]++;
                if (f_b[i])  rq_active[i] = 0;
                if (rq_active[i] == 0 && rq_q[i].size() > 0 && (rand_mode == 0 || $urandom_range(3) == 0)) begin
                    t = rq_q[i].pop_front();
                    rq_active[i] = 1; rq_awdone[i] = 0; rq_beat[i] = 0;
                    rq_len[i] = t.len; rq_bad[i] = t.bad; rq_id[i] = 4'(t.id);
                    rq_addr[i] = $urandom;
                end
                S_AWVALID[i] = (rq_active[i] != 0) && (rq_awdone[i] == 0) && (rand_mode == 0 || $urandom_range(5) != 0);
                S_AWPAY[i*AWPAY_W +: AWPAY_W] = {rq_id[i], rq_addr[i], 4'(rq_len[i]), 3'd2, 2'b01};
                S_WVALID[i] = (rq_active[i] != 0) && (rq_awdone[i] != 0) && (rq_beat[i] <= rq_len[i])
                              && (rand_mode == 0 || $urandom_range(2) != 0);
                wl = (rq_beat[i] == rq_len[i]) ^ (rq_beat[i] == rq_bad[i]);
                S_WPAY[i*WPAY_W +: WPAY_W] = {32'($urandom), 4'($urandom), wl};
                S_BREADY[i] = (rq_active[i] != 0) && (rq_awdone[i] != 0) && (rq_beat[i] > rq_len[i])
                              && (rand_mode == 0 || $urandom_range(2) != 0);
            end
            if (f_maw) dn_id = f_dnid;
            if (f_mw_last) begin
                dn_pend = 1'b1;
                if (bid_force >= 0) dn_bid = 4'(bid_force);
                else if (bid_bad_pct > 0 && $urandom_range(99) < bid_bad_pct) dn_bid = dn_id ^ 4'($urandom_range(15, 1));
                else dn_bid = dn_id;
                dn_resp = 2'($urandom);
            end
            if (f_mb) dn_pend = 1'b0;
            wr_tog = ~wr_tog;
            M_AWREADY = (rand_mode == 0) ? 1'b1 : ($urandom_range(2) != 0);
            M_WREADY  = (wr_mode == 0) ? 1'b1 : (wr_mode == 1) ? wr_tog : ($urandom_range(2) != 0);
            M_BVALID  = dn_pend && (M_BVALID || rand_mode == 0 || $urandom_range(1) == 0);
            M_BPAY    = {dn_bid, dn_resp};
        end
    end

    always @(negedge ACLK) begin
        if (ARESET) begin
            m_owner = -1; m_last = 1; m_aw_out = 0; m_left = 0; m_beat = 0; m_len = 0;
            m_awpay = '0; m_err = 1'b0; m_id = '0;
            f_aw = '0; f_w = '0; f_b = '0; f_maw = 0; f_mw_last = 0; f_mb = 0;
            mon_beats = 0; mon_lastidx = -1; mon_lastcnt = 0;
            if (chk_en) begin
                check("reset_ctl", {S_AWREADY, S_WREADY, S_BVALID, M_AWVALID, M_WVALID, M_BREADY, GRANT, ERR}, 64'd0);
                check("reset_awpay", M_AWPAY, 64'd0);
            end
        end else if (chk_en) begin
            e_awr = '0; e_wr = '0; e_bv = '0; e_gr = '0; e_awv = 0; e_wv = 0; e_br = 0; win = -1;
            if (m_owner < 0) begin
                if (S_AWVALID[1 - m_last]) win = 1 - m_last;
                else if (S_AWVALID[m_last]) win = m_last;
                if (win >= 0) e_awr[win] = 1'b1;
            end else begin
                e_gr[m_owner] = 1'b1;
                e_awv = m_aw_out;
                if (!m_aw_out && m_left > 0) begin
                    e_wv = S_WVALID[m_owner];
                    e_wr[m_owner] = M_WREADY;
                end
                if (!m_aw_out && m_left == 0) begin
                    e_br = S_BREADY[m_owner];
                    e_bv[m_owner] = M_BVALID;
                end
            end
            check("ctl", {S_AWREADY, S_WREADY, S_BVALID, M_AWVALID, M_WVALID, M_BREADY, GRANT, ERR},
                  {e_awr, e_wr, e_bv, e_awv, e_wv, e_br, e_gr, m_err});
            check("m_awpay", M_AWPAY, m_awpay);
            if (e_wv) check("m_wpay", M_WPAY, {S_WPAY[m_owner*WPAY_W + 1 +: 36], (m_beat == m_len)});
            if (e_bv != 0) check("s_bpay", S_BPAY, {m_id, M_BPAY[1:0]});

            // DUT-side observation for the directed literal checks
            f_aw = S_AWVALID & S_AWREADY; f_w = S_WVALID & S_WREADY; f_b = S_BVALID & S_BREADY;
            f_maw = M_AWVALID & M_AWREADY; f_dnid = M_AWPAY[44:41];
            f_mw_last = M_WVALID & M_WREADY & M_WPAY[0]; f_mb = M_BVALID & M_BREADY;
            if (f_maw) begin
                lg_grant.push_back(GRANT); lg_dnid.push_back(f_dnid);
                mon_beats = 0; mon_lastidx = -1; mon_lastcnt = 0;
            end
            if (M_WVALID && M_WREADY) begin
                if (M_WPAY[0]) begin mon_lastcnt++; mon_lastidx = mon_beats; end
                mon_beats++;
            end
            if (f_b != 0) begin
                lg_beats.push_back(mon_beats); lg_lastidx.push_back(mon_lastidx);
                lg_lastcnt.push_back(mon_lastcnt); lg_bid.push_back(S_BPAY[5:2]);
            end

            // model advance for the coming clock edge
            if (m_owner < 0) begin
                if (win >= 0) begin
                    mp = S_AWPAY[win*AWPAY_W +: AWPAY_W];
                    m_id = mp[44:41]; m_len = int'(mp[8:5]);
                    mp[44] = 1'(win);
                    m_awpay = mp; m_owner = win; m_aw_out = 1; m_beat = 0; m_left = m_len + 1;
                end
            end else if (m_aw_out) begin
                if (M_AWREADY) m_aw_out = 0;
            end else if (m_left > 0) begin
                if (S_WVALID[m_owner] && M_WREADY) begin
                    if (S_WPAY[m_owner*WPAY_W] != (m_beat == m_len)) m_err = 1'b1;
                    m_beat++; m_left--;
                end
            end else if (S_BREADY[m_owner] && M_BVALID) begin
                if (M_BPAY[5:2] != m_awpay[44:41]) m_err = 1'b1;
                m_last = m_owner; m_owner = -1;
            end
        end
    end

    task automatic clear_logs();
        lg_grant.delete(); lg_dnid.delete(); lg_beats.delete();
        lg_lastidx.delete(); lg_lastcnt.delete(); lg_bid.delete();
    endtask

    task automatic do_reset();
        @(posedge ACLK); #2; ARESET = 1'b1;
        repeat (2) @(posedge ACLK);
        #2; ARESET = 1'b0;
        clear_logs();
    endtask

    task automatic push(input int r, input int id, input int len, input int bad);
        txn_t x;
        x.id = id; x.len = len; x.bad = bad;
        rq_q[r].push_back(x);
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while ((rq_q[0].size() + rq_q[1].size() > 0 || rq_active[0] != 0 || rq_active[1] != 0) && n < budget) begin
            @(negedge ACLK); n++;
        end
        tests++;
        if (n >= budget) begin
            fails++;
            $display("FAIL %s timeout: waited %0d cycles, required < %0d", name, n, budget);
        end
        repeat (3) @(negedge ACLK);
        #1;
    endtask

    initial begin
        ARESET = 1'b1;
        S_AWVALID = '0; S_WVALID = '0; S_BREADY = '0; S_AWPAY = '0; S_WPAY = '0;
        M_AWREADY = 1'b0; M_WREADY = 1'b0; M_BVALID = 1'b0; M_BPAY = '0;
        dn_pend = 1'b0; wr_tog = 1'b0; dn_id = '0; dn_bid = '0; dn_resp = '0;
        repeat (2) @(posedge ACLK);
        chk_en = 1;
        @(negedge ACLK); #1;
        check("rst_grant", GRANT, 2'b00);

        // single requester, AWID=5, AWLEN=3
        do_reset();
        push(0, 5, 3, -1);
        wait_done("t1", 200);
        check("t1_n", lg_bid.size(), 1);
        if (lg_bid.size() >= 1) begin
            check("t1_grant", lg_grant[0], 2'b01);
            check("t1_dnid", lg_dnid[0], 4'd5);
            check("t1_beats", lg_beats[0], 4);
            check("t1_lastidx", lg_lastidx[0], 3);
            check("t1_lastcnt", lg_lastcnt[0], 1);
            check("t1_bid", lg_bid[0], 4'd5);
        end
        check("t1_err", ERR, 1'b0);

        // both requesters continuously valid, single beats
        do_reset();
        push(0, 1, 0, -1); push(0, 1, 0, -1);
        push(1, 1, 0, -1); push(1, 1, 0, -1);
        wait_done("t2", 200);
        check("t2_n", lg_grant.size(), 4);
        if (lg_grant.size() >= 4) begin
            check("t2_grants", {lg_grant[0], lg_grant[1], lg_grant[2], lg_grant[3]}, 8'b01_10_01_10);
            check("t2_idbit3", {lg_dnid[0][3], lg_dnid[1][3], lg_dnid[2][3], lg_dnid[3][3]}, 4'b0101);
        end

        // requester 1, 16-beat burst with toggling WREADY
        do_reset();
        wr_mode = 1;
        push(1, 2, 15, -1);
        wait_done("t3", 300);
        check("t3_n", lg_bid.size(), 1);
        if (lg_bid.size() >= 1) begin
            check("t3_grant", lg_grant[0], 2'b10);
            check("t3_dnid", lg_dnid[0], 4'd10);
            check("t3_beats", lg_beats[0], 16);
            check("t3_lastidx", lg_lastidx[0], 15);
            check("t3_bid", lg_bid[0], 4'd2);
        end
        check("t3_err", ERR, 1'b0);
        wr_mode = 0;

        // early WLAST from the master: counted length wins, ERR sticks
        do_reset();
        push(0, 1, 2, 1);
        wait_done("t4a", 200);
        if (lg_beats.size() >= 1) begin
            check("t4_beats", lg_beats[0], 3);
            check("t4_lastidx", lg_lastidx[0], 2);
            check("t4_lastcnt", lg_lastcnt[0], 1);
        end
        check("t4_err", ERR, 1'b1);
        push(0, 1, 1, -1);
        wait_done("t4b", 200);
        check("t4_err_sticky", ERR, 1'b1);
        check("t4_n", lg_beats.size(), 2);

        // downstream returns the wrong BID
        do_reset();
        bid_force = 3;
        push(1, 3, 0, -1);
        wait_done("t5", 200);
        bid_force = -1;
        check("t5_n", lg_bid.size(), 1);
        if (lg_bid.size() >= 1) begin
            check("t5_dnid", lg_dnid[0], 4'd11);
            check("t5_bid", lg_bid[0], 4'd3);
        end
        check("t5_err", ERR, 1'b1);
        check("t5_idle", GRANT, 2'b00);

        // reset in the middle of the data phase
        do_reset();
        push(0, 4, 5, -1);
        begin
            int n = 0;
            while (mon_beats != 2 && n < 100) begin @(negedge ACLK); #1; n++; end
            check("t6_reach2", mon_beats, 2);
        end
        @(posedge ACLK); #2; ARESET = 1'b1;
        @(negedge ACLK); #1;
        check("t6_rst_out", {GRANT, M_AWVALID, M_WVALID, S_WREADY, S_BVALID, M_BREADY, ERR}, 64'd0);
        check("t6_rst_awpay", M_AWPAY, 64'd0);
        @(posedge ACLK); #2; ARESET = 1'b0;
        clear_logs();
        push(0, 6, 0, -1); push(1, 7, 0, -1);
        wait_done("t6", 200);
        check("t6_n", lg_grant.size(), 2);
        if (lg_grant.size() >= 1) check("t6_first", lg_grant[0], 2'b01);

        // randomised traffic against the model
        do_reset();
        rand_mode = 1; wr_mode = 2; bid_bad_pct = 4;
        for (int i = 0; i < 30; i++) begin
            for (int r = 0; r < 2; r++) begin
                int len, bad;
                len = ($urandom_range(9) == 0) ? 15 : int'($urandom_range(3));
                bad = ($urandom_range(15) == 0) ? int'($urandom_range(len)) : -1;
                push(r, int'($urandom_range(15)), len, bad);
            end
        end
        wait_done("rand", 20000);
        check("rand_n", lg_bid.size(), 60);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/axi_wr_arb.md
Name: axi_wr_arb

Overview:
- Two-requester round-robin arbiter that shares one AXI3 write port (AW/W/B channels) between two upstream write masters.
- Serialises whole write transactions: address, then all data beats, then response.
- Only one transaction is outstanding downstream at a time.
- Sits between the DMA/CPU-side write masters and the single AXI slave port on the bus.

Parameters:
N_REQ, 2, number of requesters (design and verification fixed at 2)
AWPAY_W, 45, AW payload width {AWID[3:0],AWADDR[31:0],AWLEN[3:0],AWSIZE[2:0],AWBURST[1:0]}
WPAY_W, 37, W payload width {WDATA[31:0],WSTRB[3:0],WLAST}
BPAY_W, 6, B payload width {BID[3:0],BRESP[1:0]}

Ports:
ACLK  in  1  clock
ARESET  in  1  asynchronous reset, active-high
S_AWVALID  in  N_REQ  per-requester address valid
S_AWREADY  out  N_REQ  per-requester address ready
S_AWPAY  in  N_REQ*AWPAY_W  packed per-requester AW payload, requester i at slice i
S_WVALID  in  N_REQ  data valid
S_WREADY  out  N_REQ  data ready
S_WPAY  in  N_REQ*WPAY_W  packed W payloads
S_BVALID  out  N_REQ  response valid
S_BREADY  in  N_REQ  response ready
S_BPAY  out  BPAY_W  response payload, shared by all requesters, qualified by S_BVALID
M_AWVALID  out  1  downstream address valid
M_AWREADY  in  1  downstream address ready
M_AWPAY  out  AWPAY_W  downstream AW payload, registered
M_WVALID  out  1  downstream data valid
M_WREADY  in  1  downstream data ready
M_WPAY  out  WPAY_W  downstream W payload
M_BVALID  in  1  downstream response valid
M_BREADY  out  1  downstream response ready
M_BPAY  in  BPAY_W  downstream response payload
GRANT  out  N_REQ  one-hot owner of the current transaction; 0 in IDLE
ERR  out  1  sticky protocol error flag

Behaviour:
- Reset state: IDLE. All valid/ready outputs, GRANT, ERR, M_AWPAY and beat counter are 0. last_grant = 1, so requester 0 wins first.
- FSM states: IDLE -> AW -> W -> B -> IDLE.
- IDLE:
  - Winner = first set S_AWVALID bit scanning from last_grant+1 (mod 2).
  - S_AWREADY[winner] = 1 combinationally in the same cycle.
  - On that handshake:
    - Register the AW payload.
    - Overwrite AWID[3] with the winner index.
    - Store the original AWID and AWLEN.
    - Set GRANT and M_AWVALID; go to AW.
  - Latency: M_AWVALID rises 1 cycle after the accepted S_AWVALID.
- AW:
  - Hold M_AWVALID and M_AWPAY stable until M_AWREADY.
  - On handshake: clear M_AWVALID, beat_cnt = 0, go to W.
  - S_AWREADY = 0 for all requesters.
- W:
  - Combinational: M_WVALID = S_WVALID[g]; S_WREADY[g] = M_WREADY; WDATA/WSTRB passed through from the granted requester.
  - M_WPAY.WLAST is generated as (beat_cnt == AWLEN); the requester's WLAST is ignored on the bus.
  - Each M_WVALID & M_WREADY beat increments the 4-bit beat_cnt.
  - On the beat where beat_cnt == AWLEN, go to B.
  - If the requester's WLAST differs from the generated WLAST on any accepted beat, set ERR. The transfer still completes using the counted length.
  - The non-granted requester sees S_WREADY = 0.
- B:
  - Combinational: M_BREADY = S_BREADY[g]; S_BVALID[g] = M_BVALID.
  - S_BPAY = {stored original AWID, M_BPAY.BRESP}.
  - If M_BPAY.BID differs from the issued ID, set ERR.
  - On handshake: last_grant = g, GRANT = 0, go to IDLE.
  - The next arbitration happens in the following cycle, giving a 1-cycle bubble between transactions.
- Both requesters valid in IDLE: alternate strictly (0,1,0,1...).
- A requester deasserting AWVALID before its grant is permitted; the other requester may win instead.
- AWLEN = 0: single beat, WLAST = 1 on beat 0.
- AWLEN = 15: 16 beats; beat_cnt does not wrap before the exit condition.
- ARESET asserted mid-transaction: immediate return to the reset state. Downstream is not drained; the bus must be reset together with this block.
- ERR clears only on reset.

Decomposition:
- Shared package axi_pkg holds:
  - payload field offsets and widths (AWID_LSB, AWLEN_LSB, WLAST_BIT, ...)
  - BRESP constants (OKAY, EXOKAY, SLVERR, DECERR)
  - FSM state encoding (IDLE, AW, W, B)
- Optional sub-module rr_arb2: 2-way round-robin picker (req[1:0], last[0] -> gnt[1:0]).

Test Plan:
- Requester 0 only, AWID=5, AWLEN=3, M_*READY always 1 -> M_AWPAY.AWID=5, 4 W beats with WLAST on beat 3, S_BPAY.BID=5 to requester 0, ERR=0.
- Both S_AWVALID held high continuously, AWLEN=0 -> GRANT sequence 01,10,01,10; downstream AWID[3] alternates 0,1,0,1.
- Requester 1 AWID=2, AWLEN=15, M_WREADY toggles 1/0 -> exactly 16 beats, M_AWPAY.AWID=10, returned BID=2.
- Requester sends WLAST on beat 1 with AWLEN=2 -> downstream WLAST only on beat 2, ERR=1 and stays 1.
- Downstream returns BID=3 for issued ID 11 -> ERR=1; response is still forwarded; FSM returns to IDLE.
- ARESET pulsed during the W state after 2 beats -> all outputs 0 on the reset edge; the next transaction is granted to requester 0.
